// File: rtl/hazard_ctrl_if.sv
// Pipeline-hazard bus: register indices and control bits from the D/E/M/W
// stages towards the sequencer, and stall/flush/forward controls back.
interface hazard_ctrl_if #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] ra1_D;
  logic [REG_W-1:0] ra2_D;
  logic [REG_W-1:0] ra1_E;
  logic [REG_W-1:0] ra2_E;
  logic [REG_W-1:0] regScr_E;
  logic             regw_E;
  logic             regmem_E;
  logic [REG_W-1:0] regScr_M;
  logic             regw_M;
  logic             memreq_M;
  logic             mem_ready;
  logic [REG_W-1:0] regScr_W;
  logic             regw_W;
  logic             branch_E;
  logic [1:0]       fwdA_E;
  logic [1:0]       fwdB_E;
  logic             stall_F;
  logic             stall_D;
  logic             stall_E;
  logic             stall_M;
  logic             flush_D;
  logic             flush_E;
  logic             flush_W;
  logic             mem_fault;
  logic [CNT_W-1:0] stall_cycles;

  // Pipeline side: supplies stage information, consumes sequencing controls.
  modport master (
    output ra1_D, ra2_D, ra1_E, ra2_E, regScr_E, regw_E, regmem_E,
           regScr_M, regw_M, memreq_M, mem_ready, regScr_W, regw_W, branch_E,
    input  fwdA_E, fwdB_E, stall_F, stall_D, stall_E, stall_M,
           flush_D, flush_E, flush_W, mem_fault, stall_cycles
  );

  // Sequencer side.
  modport slave (
    input  ra1_D, ra2_D, ra1_E, ra2_E, regScr_E, regw_E, regmem_E,
           regScr_M, regw_M, memreq_M, mem_ready, regScr_W, regw_W, branch_E,
    output fwdA_E, fwdB_E, stall_F, stall_D, stall_E, stall_M,
           flush_D, flush_E, flush_W, mem_fault, stall_cycles
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: forwarding select, load-use stall,
// branch squash, and a memory-wait freeze with a watchdog fault trap.
module hazard_ctrl #(
  parameter int REG_W     = 4,
  parameter int NOFWD_REG = 15,
  parameter int MAX_WAIT  = 15,
  parameter int CNT_W     = 16
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {RUN, MEMWAIT, FAULT} state_t;

  state_t           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             mem_fault_q, mem_fault_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  logic [1:0] fwd_a, fwd_b;
  logic       ldstall;
  logic       st_f, st_d, st_e, st_m, fl_d, fl_e, fl_w;

  // Forwarding select: the younger M result takes priority over W.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (hz.regw_M && hz.regScr_M == hz.ra1_E && hz.ra1_E != REG_W'(NOFWD_REG))
      fwd_a = 2'b10;
    else if (hz.regw_W && hz.regScr_W == hz.ra1_E && hz.ra1_E != REG_W'(NOFWD_REG))
      fwd_a = 2'b01;
    if (hz.regw_M && hz.regScr_M == hz.ra2_E && hz.ra2_E != REG_W'(NOFWD_REG))
      fwd_b = 2'b10;
    else if (hz.regw_W && hz.regScr_W == hz.ra2_E && hz.ra2_E != REG_W'(NOFWD_REG))
      fwd_b = 2'b01;
  end

  assign ldstall = hz.regmem_E && hz.regw_E &&
                   (hz.regScr_E == hz.ra1_D || hz.regScr_E == hz.ra2_D);

  // Sequencer: next state and stall/flush decode from state and current inputs.
  // A MEMWAIT cycle that sees mem_ready falls through to the RUN decode so the
  // held branch/load-use condition is acted on in the release cycle itself.
  always_comb begin
    logic freeze;
    logic use_run;
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_fault_d = mem_fault_q;
    freeze      = 1'b0;
    use_run     = 1'b0;
    st_f = 1'b0; st_d = 1'b0; st_e = 1'b0; st_m = 1'b0;
    fl_d = 1'b0; fl_e = 1'b0; fl_w = 1'b0;

    case (state_q)
      RUN: use_run = 1'b1;
      MEMWAIT: begin
        if (hz.mem_ready) begin
          use_run    = 1'b1;
          state_d    = RUN;
          wait_cnt_d = '0;
        end else begin
          freeze = 1'b1;
          if (wait_cnt_q == 8'(MAX_WAIT)) begin
            state_d     = FAULT;
            mem_fault_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end
      end
      FAULT: begin
        freeze      = 1'b1;
        mem_fault_d = 1'b1;
      end
      default: state_d = RUN;
    endcase

    if (use_run) begin
      if (hz.memreq_M && !hz.mem_ready) begin
        freeze     = 1'b1;
        state_d    = MEMWAIT;
        wait_cnt_d = 8'd1;
      end else if (hz.branch_E) begin
        fl_d = 1'b1;
        fl_e = 1'b1;
      end else if (ldstall) begin
        st_f = 1'b1;
        st_d = 1'b1;
        fl_e = 1'b1;
      end
    end

    if (freeze) begin
      st_f = 1'b1; st_d = 1'b1; st_e = 1'b1; st_m = 1'b1;
      fl_w = 1'b1;
    end

    if (rst) begin
      st_f = 1'b0; st_d = 1'b0; st_e = 1'b0; st_m = 1'b0;
      fl_d = 1'b1; fl_e = 1'b1; fl_w = 1'b1;
    end

    stall_cycles_d = stall_cycles_q;
    if (st_f && stall_cycles_q != '1)
      stall_cycles_d = stall_cycles_q + 1'b1;
  end

  // State, watchdog, sticky fault and performance counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      wait_cnt_q     <= '0;
      mem_fault_q    <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_fault_q    <= mem_fault_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign hz.fwdA_E       = rst ? 2'b00 : fwd_a;
  assign hz.fwdB_E       = rst ? 2'b00 : fwd_b;
  assign hz.stall_F      = st_f;
  assign hz.stall_D      = st_d;
  assign hz.stall_E      = st_e;
  assign hz.stall_M      = st_m;
  assign hz.flush_D      = fl_d;
  assign hz.flush_E      = fl_e;
  assign hz.flush_W      = fl_w;
  assign hz.mem_fault    = mem_fault_q;
  assign hz.stall_cycles = stall_cycles_q;

endmodule
